// File: rtl/cordic_byte_link_if.sv
// Pin-side byte stream and core-side word handshake bundled for cordic_byte_link.
// slave = the framing link itself; master = the surrounding pins and CORDIC core.
interface cordic_byte_link_if #(
  parameter int unsigned IN_BYTES  = 4,
  parameter int unsigned OUT_BYTES = 6
);
  logic                   ena;
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [8*IN_BYTES-1:0]  core_in;
  logic                   core_start;
  logic                   core_done;
  logic [8*OUT_BYTES-1:0] core_out;
  logic                   frame_err;
  logic [7:0]             frame_cnt;

  modport slave (
    input  ena, in_data, in_valid, out_ready, core_done, core_out,
    output in_ready, out_data, out_valid, core_in, core_start, frame_err, frame_cnt
  );

  modport master (
    output ena, in_data, in_valid, out_ready, core_done, core_out,
    input  in_ready, out_data, out_valid, core_in, core_start, frame_err, frame_cnt
  );
endinterface

// File: rtl/cordic_byte_link.sv
// Byte-serial framing engine: deserialises operand frames into a CORDIC core and serialises results.
// Optional feature: define FRAME_CSUM_EN to add an XOR checksum byte to input and output frames.
module cordic_byte_link #(
  parameter int unsigned IN_BYTES       = 4,
  parameter int unsigned OUT_BYTES      = 6,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input logic               clk,
  input logic               rst_n,
  cordic_byte_link_if.slave bus
);

`ifdef FRAME_CSUM_EN
  localparam int unsigned CSUM_BYTES = 1;
`else
  localparam int unsigned CSUM_BYTES = 0;
`endif
  localparam int unsigned RX_LEN    = IN_BYTES + CSUM_BYTES;
  localparam int unsigned TX_LEN    = OUT_BYTES + CSUM_BYTES;
  localparam int unsigned MAX_BYTES = (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES;
  localparam int unsigned CW        = $clog2(MAX_BYTES + 2);
  localparam int unsigned SRW       = 8*TX_LEN + 8;
  localparam int unsigned IW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {RX, START, WAIT, TX} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic [8*IN_BYTES-1:0] core_in_q, core_in_d;
  logic [SRW-1:0]        tx_sr_q, tx_sr_d;
  logic [7:0]            out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  core_start_q, core_start_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
`ifdef FRAME_CSUM_EN
  logic [7:0]            rx_csum_q, rx_csum_d;
  logic [7:0]            tx_csum;

  always_comb begin
    tx_csum = '0;
    for (int unsigned i = 0; i < OUT_BYTES; i++) tx_csum = tx_csum ^ bus.core_out[8*i +: 8];
  end
`endif

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    idle_d       = idle_q;
    core_in_d    = core_in_q;
    tx_sr_d      = tx_sr_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    in_ready_d   = in_ready_q;
    core_start_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
`ifdef FRAME_CSUM_EN
    rx_csum_d    = rx_csum_q;
`endif
    if (!bus.ena) begin
      state_d     = RX;
      byte_cnt_d  = '0;
      idle_d      = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b0;
`ifdef FRAME_CSUM_EN
      rx_csum_d   = '0;
`endif
    end else begin
      unique case (state_q)
        RX: begin
          in_ready_d = 1'b1;
          if (bus.in_valid && in_ready_q) begin
            idle_d     = '0;
            byte_cnt_d = byte_cnt_q + 1'b1;
            // The checksum byte has byte_cnt == IN_BYTES, so it never lands in a lane.
            for (int unsigned i = 0; i < IN_BYTES; i++) begin
              if (byte_cnt_q == CW'(i)) core_in_d[8*i +: 8] = bus.in_data;
            end
`ifdef FRAME_CSUM_EN
            rx_csum_d = rx_csum_q ^ bus.in_data;
`endif
            if (byte_cnt_q == CW'(RX_LEN - 1)) begin
              byte_cnt_d = '0;
`ifdef FRAME_CSUM_EN
              rx_csum_d = '0;
              if (bus.in_data != rx_csum_q) begin
                frame_err_d = 1'b1;
              end else begin
                state_d      = START;
                in_ready_d   = 1'b0;
                core_start_d = 1'b1;
              end
`else
              state_d      = START;
              in_ready_d   = 1'b0;
              core_start_d = 1'b1;
`endif
            end
          end else if (TIMEOUT_CYCLES != 0 && byte_cnt_q != '0) begin
            if (idle_q == IW'(TO_LAST)) begin
              idle_d      = '0;
              byte_cnt_d  = '0;
              frame_err_d = 1'b1;
`ifdef FRAME_CSUM_EN
              rx_csum_d   = '0;
`endif
            end else begin
              idle_d = idle_q + 1'b1;
            end
          end
        end
        START: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (bus.core_done) begin
`ifdef FRAME_CSUM_EN
            tx_sr_d = SRW'({tx_csum, bus.core_out});
`else
            tx_sr_d = SRW'(bus.core_out);
`endif
            out_data_d  = bus.core_out[7:0];
            out_valid_d = 1'b1;
            byte_cnt_d  = '0;
            state_d     = TX;
          end
        end
        TX: begin
          if (out_valid_q && bus.out_ready) begin
            if (byte_cnt_q == CW'(TX_LEN - 1)) begin
              out_valid_d = 1'b0;
              frame_cnt_d = frame_cnt_q + 8'd1;
              byte_cnt_d  = '0;
              in_ready_d  = 1'b1;
              state_d     = RX;
            end else begin
              // out_data is pre-loaded with the next byte so it is registered at the pin.
              out_data_d = tx_sr_q[15:8];
              tx_sr_d    = tx_sr_q >> 8;
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX;
      byte_cnt_q   <= '0;
      idle_q       <= '0;
      core_in_q    <= '0;
      tx_sr_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef FRAME_CSUM_EN
      rx_csum_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_q       <= idle_d;
      core_in_q    <= core_in_d;
      tx_sr_q      <= tx_sr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      core_start_q <= core_start_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef FRAME_CSUM_EN
      rx_csum_q    <= rx_csum_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.core_in    = core_in_q;
  assign bus.core_start = core_start_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule
